// File: rtl/series_pkg.sv
// Shared definitions for the series-evaluation job arbiter.
//   X_W / Y_W        : operand/result widths (9.8 signed, 1.7 unsigned)
//   TIMEOUT_DEFAULT  : default watchdog limit in cycles
//   state_e          : arbiter FSM state encoding
//   idx_width()      : width of a requester index for a given requester count
package series_pkg;

    localparam int unsigned X_W             = 17;
    localparam int unsigned Y_W             = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StLaunch   = 3'd1,
        StWaitBusy = 3'd2,
        StWaitDone = 3'd3,
        StResp     = 3'd4
    } state_e;

    // A single requester still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req        : pending request vector
//   last_grant : index granted most recently
//   valid      : at least one request pending
//   index      : first pending requester searching upward from last_grant+1 (mod NREQ)
module rr_pick
    import series_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            valid,
    output logic [IW-1:0]   index
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        // Offset NREQ wraps back to last_grant itself, so it has lowest priority.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!valid && req[(32'(last_grant) + i) % NREQ]) begin
                valid = 1'b1;
                index = IW'((32'(last_grant) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/series_job_arbiter.sv
// Shares one series-evaluation engine between NREQ requesters.
// Round-robin grant, operand latching, engine launch/handshake tracking,
// watchdog abort and one-cycle done pulse back to the winner.
//   clk, rst        : clock, asynchronous active-low reset
//   req/x_in/y_in   : per-requester level request and flattened operands
//   done/err/result : completion pulse, timeout flag, signed result
//   busy            : a job is in flight
//   eng_start/x/y   : launch pulse and latched operands to the engine
//   eng_ready/rout  : engine idle/done flag and its result
module series_job_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned X_W     = series_pkg::X_W,
    parameter int unsigned Y_W     = series_pkg::Y_W,
    parameter int unsigned TIMEOUT = series_pkg::TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*X_W-1:0] x_in,
    input  logic [NREQ*Y_W-1:0] y_in,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic [X_W-1:0]      result,
    output logic                busy,
    output logic                eng_start,
    output logic [X_W-1:0]      eng_x,
    output logic [Y_W-1:0]      eng_y,
    input  logic                eng_ready,
    input  logic [X_W-1:0]      eng_rout
);

    import series_pkg::*;

    localparam int unsigned IW = idx_width(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_e          r_state;
    logic [IW-1:0]   r_cur;
    logic [IW-1:0]   r_last;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_done;
    logic            r_err;
    logic [X_W-1:0]  r_result;
    logic            r_busy;
    logic            r_start;
    logic [X_W-1:0]  r_x;
    logic [Y_W-1:0]  r_y;

    logic            w_valid;
    logic [IW-1:0]   w_index;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (r_last),
        .valid      (w_valid),
        .index      (w_index)
    );

    // Abort fires on the edge where the cycle count in the wait states hits TIMEOUT.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_cur    <= '0;
            r_last   <= IW'(NREQ - 1);
            r_cnt    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            // Pulses default low; they are raised on the edge entering their state.
            r_start <= 1'b0;
            r_done  <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_valid) begin
                        r_cur   <= w_index;
                        r_x     <= x_in[w_index*X_W +: X_W];
                        r_y     <= y_in[w_index*Y_W +: Y_W];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= StLaunch;
                    end
                end
                StLaunch: begin
                    r_cnt   <= '0;
                    r_state <= StWaitBusy;
                end
                StWaitBusy: begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_done   <= NREQ'(1) << r_cur;
                        r_state  <= StResp;
                    end else if (!eng_ready) begin
                        r_state <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    r_cnt <= w_cnt_inc;
                    // Normal completion takes priority over a coincident timeout.
                    if (eng_ready) begin
                        r_result <= eng_rout;
                        r_err    <= 1'b0;
                        r_done   <= NREQ'(1) << r_cur;
                        r_state  <= StResp;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_done   <= NREQ'(1) << r_cur;
                        r_state  <= StResp;
                    end
                end
                StResp: begin
                    r_last  <= r_cur;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign busy      = r_busy;
    assign eng_start = r_start;
    assign eng_x     = r_x;
    assign eng_y     = r_y;

endmodule

// File: tb/tb_series_job_arbiter.sv
// Randomized scoreboard bench for series_job_arbiter with a behavioural engine model.
module tb_series_job_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned XW   = 17;
    localparam int unsigned YW   = 8;
    localparam int          TO   = 40;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req;
    logic [NREQ*XW-1:0]   x_in;
    logic [NREQ*YW-1:0]   y_in;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [XW-1:0]        result;
    logic                 busy;
    logic                 eng_start;
    logic [XW-1:0]        eng_x;
    logic [YW-1:0]        eng_y;
    logic                 eng_ready;
    logic [XW-1:0]        eng_rout;

    always #5 clk = ~clk;

    series_job_arbiter #(
        .NREQ    (NREQ),
        .X_W     (XW),
        .Y_W     (YW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .done      (done),
        .err       (err),
        .result    (result),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_ready (eng_ready),
        .eng_rout  (eng_rout)
    );

    // Requester-side state, one element per requester.
    logic          tb_req [NREQ] = '{default: 1'b0};
    logic [XW-1:0] tb_x   [NREQ] = '{default: '0};
    logic [YW-1:0] tb_y   [NREQ] = '{default: '0};
    int            jobs_target [NREQ] = '{default: 0};
    int            jobs_served [NREQ] = '{default: 0};
    bit            hold   [NREQ] = '{default: 1'b0};
    bit            kill   [NREQ] = '{default: 1'b0};
    bit            dir_on [NREQ] = '{default: 1'b0};
    logic [XW-1:0] dir_x  [NREQ] = '{default: '0};
    logic [YW-1:0] dir_y  [NREQ] = '{default: '0};

    always_comb begin
        req  = '0;
        x_in = '0;
        y_in = '0;
        for (int k = 0; k < NREQ; k++) begin
            req[k]             = tb_req[k];
            x_in[k*XW +: XW]   = tb_x[k];
            y_in[k*YW +: YW]   = tb_y[k];
        end
    end

    typedef struct {
        int            acc;
        int            dly;
        bit            hang;
        logic [XW-1:0] val;
    } cfg_t;

    typedef struct {
        int            k;
        logic [XW-1:0] res;
        bit            err;
        int            cyc;
    } exp_t;

    cfg_t cfg_q[$];
    exp_t exp_q[$];
    int   grant_log[$];

    int n_chk   = 0;
    int n_pass  = 0;
    int n_start = 0;
    int n_done  = 0;
    int cyc     = 0;
    int rst_cnt = 0;
    logic [NREQ-1:0] req_smp = '0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        req_smp <= req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Engine model plus grant predictor: on each launch it decides the engine's
    // behaviour and pushes the response the winner must later see.
    initial begin
        int   model_last;
        int   rst_seen;
        int   k;
        int   c0;
        cfg_t c;
        exp_t e;
        model_last = NREQ - 1;
        rst_seen   = 0;
        eng_ready  = 1'b1;
        eng_rout   = '0;
        forever begin
            @(negedge clk);
            if (rst && eng_start) begin
                n_start++;
                c0 = cyc;
                if (rst_cnt != rst_seen) begin
                    model_last = NREQ - 1;
                    rst_seen   = rst_cnt;
                end
                k = -1;
                for (int i = 1; i <= NREQ; i++) begin
                    if (k < 0 && req_smp[(model_last + i) % NREQ]) k = (model_last + i) % NREQ;
                end
                check("start_had_request", 32'(k >= 0), 1);
                if (k < 0) k = 0;
                check("start_busy", 32'(busy), 1);
                check("launch_x", 32'(eng_x), 32'(tb_x[k]));
                check("launch_y", 32'(eng_y), 32'(tb_y[k]));
                model_last = k;
                grant_log.push_back(k);
                if (cfg_q.size() != 0) begin
                    c = cfg_q.pop_front();
                end else begin
                    c.acc  = $urandom_range(1, 3);
                    c.dly  = $urandom_range(1, 20);
                    c.hang = ($urandom_range(0, 7) == 0);
                    c.val  = 17'($urandom);
                end
                if (c.hang) begin
                    c.acc = 1;
                    e = '{k: k, res: '0, err: 1'b1, cyc: c0 + 1 + TO};
                end else begin
                    e = '{k: k, res: c.val, err: 1'b0, cyc: c0 + c.acc + c.dly + 1};
                end
                exp_q.push_back(e);
                repeat (c.acc) @(posedge clk);
                #1 eng_ready = 1'b0;
                if (c.hang) begin
                    while (cyc < c0 + 1 + TO) begin
                        @(posedge clk);
                        #1;
                    end
                    eng_ready = 1'b1;
                end else begin
                    repeat (c.dly) @(posedge clk);
                    #1;
                    eng_rout  = c.val;
                    eng_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: every done pulse is matched against the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
            end else if (done !== '0) begin
                n_done++;
                check("done_onehot", 32'($onehot(done)), 1);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL done_unexpected: got done=%b with nothing outstanding", done);
                end else begin
                    e = exp_q.pop_front();
                    check("done_vec", 32'(done), 32'(1 << e.k));
                    check("result", 32'(result), 32'(e.res));
                    check("err", 32'(err), 32'(e.err));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic requester(input int k);
        int budget;
        forever begin
            @(posedge clk);
            #1;
            if (rst && jobs_served[k] != jobs_target[k]) begin
                tb_x[k]   = dir_on[k] ? dir_x[k] : 17'($urandom);
                tb_y[k]   = dir_on[k] ? dir_y[k] : 8'($urandom);
                tb_req[k] = 1'b1;
                while (jobs_served[k] != jobs_target[k]) begin
                    budget = 0;
                    do begin
                        @(negedge clk);
                        budget++;
                    end while (done[k] !== 1'b1 && !kill[k] && budget < 2000);
                    if (kill[k]) begin
                        jobs_served[k] = jobs_target[k];
                        tb_req[k]      = 1'b0;
                        break;
                    end
                    if (done[k] !== 1'b1) begin
                        fail("requester_wait_done");
                        jobs_served[k] = jobs_target[k];
                        tb_req[k]      = 1'b0;
                        break;
                    end
                    jobs_served[k]++;
                    @(posedge clk);
                    #1;
                    if (jobs_served[k] != jobs_target[k] && (hold[k] || $urandom_range(0, 1) == 1)) begin
                        tb_x[k] = 17'($urandom);
                        tb_y[k] = 8'($urandom);
                    end else begin
                        tb_req[k] = 1'b0;
                        if (jobs_served[k] != jobs_target[k]) begin
                            repeat ($urandom_range(1, 4)) @(posedge clk);
                            #1;
                            tb_x[k]   = 17'($urandom);
                            tb_y[k]   = 8'($urandom);
                            tb_req[k] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            fork
                automatic int kk = k;
                requester(kk);
            join_none
        end
    end

    function automatic bit pending();
        for (int k = 0; k < NREQ; k++) if (jobs_served[k] != jobs_target[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_all(input string name);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (b < 4000 && (pending() || exp_q.size() != 0 || busy));
        if (b >= 4000) fail(name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_err"},       32'(err), 0);
        check({tag, "_result"},    32'(result), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_eng_start"}, 32'(eng_start), 0);
        check({tag, "_eng_x"},     32'(eng_x), 0);
        check({tag, "_eng_y"},     32'(eng_y), 0);
    endtask

    initial begin
        int s0;
        int g0;
        int d0;
        int b;

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b1;

        // Simultaneous requests straight after reset: 0 first, then 1.
        cfg_q.push_back('{acc: 1, dly: 6, hang: 1'b0, val: 17'h00010});
        cfg_q.push_back('{acc: 1, dly: 9, hang: 1'b0, val: 17'h00020});
        g0 = grant_log.size();
        @(negedge clk);
        jobs_target[0]++;
        jobs_target[1]++;
        wait_all("simul_wait");
        check("simul_grants", 32'(grant_log.size() - g0), 2);
        if (grant_log.size() >= g0 + 2) begin
            check("simul_first", 32'(grant_log[g0]), 0);
            check("simul_second", 32'(grant_log[g0+1]), 1);
        end

        // Single job on requester 0 with fixed operands and a 20-cycle engine.
        dir_on[0] = 1'b1;
        dir_x[0]  = 17'h00002;
        dir_y[0]  = 8'h08;
        cfg_q.push_back('{acc: 1, dly: 20, hang: 1'b0, val: 17'h00102});
        s0 = n_start;
        jobs_target[0]++;
        wait_all("single_wait");
        dir_on[0] = 1'b0;
        check("single_one_start", 32'(n_start - s0), 1);
        check("single_grant", 32'(grant_log[$]), 0);
        check("single_eng_x", 32'(eng_x), 32'h00002);
        check("single_eng_y", 32'(eng_y), 32'h08);
        repeat (3) @(negedge clk);
        check("single_result_held", 32'(result), 32'h00102);
        check("single_err_held", 32'(err), 0);

        // Fairness: both hold; requester 0 gets in first and grants must alternate.
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        g0 = grant_log.size();
        jobs_target[0] += 2;
        b = 0;
        while (!busy && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!busy) fail("fair_first_grant");
        jobs_target[1] += 2;
        wait_all("fair_wait");
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        check("fair_grants", 32'(grant_log.size() - g0), 4);
        if (grant_log.size() >= g0 + 4) begin
            for (int i = 0; i < 4; i++) check("fair_order", 32'(grant_log[g0+i]), 32'(i % 2));
        end

        // Hung engine aborts with err, then a normal job follows.
        cfg_q.push_back('{acc: 1, dly: 0, hang: 1'b1, val: 17'h1ffff});
        cfg_q.push_back('{acc: 1, dly: 4, hang: 1'b0, val: 17'h15a5a});
        jobs_target[1]++;
        wait_all("timeout_wait");
        check("timeout_err_held", 32'(err), 1);
        check("timeout_result_held", 32'(result), 0);
        jobs_target[0]++;
        wait_all("post_timeout_wait");
        check("post_timeout_err", 32'(err), 0);

        // Engine keeps ready high for 3 cycles after start.
        cfg_q.push_back('{acc: 3, dly: 6, hang: 1'b0, val: 17'h1abcd});
        jobs_target[0]++;
        wait_all("late_wait");
        check("late_result", 32'(result), 32'h1abcd);

        // Reset in the middle of a job drops it silently.
        cfg_q.push_back('{acc: 1, dly: 30, hang: 1'b0, val: 17'h00777});
        jobs_target[0]++;
        b = 0;
        while (!eng_start && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!eng_start) fail("midreset_start");
        repeat (8) @(negedge clk);
        check("midreset_busy_before", 32'(busy), 1);
        #2;
        rst = 1'b0;
        rst_cnt++;
        kill[0] = 1'b1;
        #1 check_all_zero("midreset");
        d0 = n_done;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        kill[0] = 1'b0;
        check("midreset_no_done", 32'(n_done - d0), 0);
        g0 = grant_log.size();
        jobs_target[1]++;
        wait_all("midreset_next_wait");
        check("midreset_next_grants", 32'(grant_log.size() - g0), 1);
        check("midreset_next_grant", 32'(grant_log[$]), 1);

        // Randomized traffic with random engine timing and occasional hangs.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < NREQ; k++) jobs_target[k] += $urandom_range(0, 3);
            wait_all("random_wait");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
